wave_voice_ctrl: RTL

- Initiator side of the 6-bit wavetable lookup interface. Drives the table's phase index and consumes the signed 16-bit sample the table returns.
- Contains a phase accumulator (NCO) clocked by the audio sample strobe, a four-state attack/sustain/release envelope, and an envelope multiply.
- Emits one enveloped signed sample per strobe to the audio mixer.
- One instance per voice, placed between the voice register bank and the wavetable ROMs.

---
 rtl/wave_voice_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wave_voice_ctrl.sv
// One synth voice: a phase accumulator drives the wavetable index, and an ASR envelope
// scales the returned sample. The voice emits one enveloped sample per audio tick.
module wave_voice_ctrl #(
  parameter int PHASE_W = 24,
  parameter int ENV_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               key_on,
  input  logic               key_off,
  input  logic [ENV_W-1:0]   atk_rate,
  input  logic [ENV_W-1:0]   rel_rate,
  output logic [5:0]         ramp_o,
  input  logic [15:0]        wave_i,
  output logic [15:0]        sample_o,
  output logic               sample_valid,
  output logic               busy
);

  localparam int PROD_W = 16 + ENV_W + 1;
  localparam logic [ENV_W-1:0] ENV_MAX   = '1;
  localparam logic [ENV_W:0]   ENV_MAX_X = {1'b0, ENV_MAX};

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [ENV_W-1:0]     env_q, env_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [5:0]           ramp_q;
  logic                 tick1_q;
  logic [15:0]          sample_q, sample_d;
  logic                 valid_q;
  logic                 busy_q;
  logic [ENV_W:0]       env_up, env_dn;
  logic signed [PROD_W-1:0] wave_ext, env_ext, prod;

  // One extra bit catches attack overflow and release underflow.
  assign env_up = {1'b0, env_q} + {1'b0, atk_rate};
  assign env_dn = {1'b0, env_q} - {1'b0, rel_rate};

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    phase_d = phase_q;
    if (key_on) begin
      state_d = ATTACK;
      env_d   = '0;
      phase_d = '0;
    end else begin
      case (state_q)
        IDLE: ;
        ATTACK: begin
          if (key_off) begin
            state_d = RELEASE;
          end else if (sample_tick) begin
            if (atk_rate == '0 || env_up >= ENV_MAX_X) begin
              env_d   = ENV_MAX;
              state_d = SUSTAIN;
            end else begin
              env_d = env_up[ENV_W-1:0];
            end
          end
        end
        SUSTAIN: begin
          env_d = ENV_MAX;
          if (key_off) state_d = RELEASE;
        end
        RELEASE: begin
          if (sample_tick) begin
            if (rel_rate == '0 || env_dn[ENV_W] || env_dn[ENV_W-1:0] == '0) begin
              env_d   = '0;
              state_d = IDLE;
            end else begin
              env_d = env_dn[ENV_W-1:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase
      // Reaching IDLE always restarts the phase so the next note begins at index 0.
      if (state_d == IDLE) phase_d = '0;
      else if (sample_tick) phase_d = phase_q + freq_word;
    end
  end

  // The multiply is one cycle after the tick; by then env_q already holds that tick's update.
  assign wave_ext = {{(PROD_W-16){wave_i[15]}}, wave_i};
  assign env_ext  = {{(PROD_W-ENV_W){1'b0}}, env_q};
  assign prod     = wave_ext * env_ext;
  assign sample_d = 16'(prod >>> ENV_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      env_q    <= '0;
      phase_q  <= '0;
      ramp_q   <= '0;
      tick1_q  <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      phase_q <= phase_d;
      if (sample_tick) ramp_q <= phase_d[PHASE_W-1 -: 6];
      tick1_q <= sample_tick;
      valid_q <= tick1_q;
      if (tick1_q) sample_q <= sample_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign ramp_o       = ramp_q;
  assign sample_o     = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule
